// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter for AXI-Stream: holds a grant for a whole packet and
// registers the merged stream through a two-entry skid buffer.
module axis_pkt_arbiter #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  localparam int ID_WIDTH  = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic [S_COUNT-1:0]               s_axis_tvalid,
  output logic [S_COUNT-1:0]               s_axis_tready,
  input  logic [S_COUNT-1:0]               s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0]    s_axis_tuser,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  output logic                             busy,
  output logic [ID_WIDTH-1:0]              grant_idx
);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_XFER = 1'b1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [ID_WIDTH-1:0]   id;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  logic                state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
  logic                out_valid_q, out_valid_d;
  logic                skid_valid_q, skid_valid_d;
  beat_t               out_beat_q, skid_beat_q;

  logic                arb_found;
  logic [ID_WIDTH-1:0] arb_idx;
  logic                hi_found, lo_found;
  logic [ID_WIDTH-1:0] hi_idx, lo_idx;
  logic                sel_valid;
  beat_t               sel_beat;
  logic                in_ready, in_fire;
  logic                load_out, load_skid, move_skid;

  // Input readiness depends only on registered state, so m_axis_tready never
  // reaches s_axis_tready combinationally.
  assign in_ready = (state_q == STATE_XFER) && !skid_valid_q;
  assign in_fire  = in_ready && sel_valid;

  // Round-robin: lowest requester above last_grant wins, else lowest overall.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = S_COUNT - 1; i >= 0; i--) begin
      if (s_axis_tvalid[i]) begin
        lo_found = 1'b1;
        lo_idx   = ID_WIDTH'(i);
        if (i > int'(last_grant_q)) begin
          hi_found = 1'b1;
          hi_idx   = ID_WIDTH'(i);
        end
      end
    end
    arb_found = lo_found;
    arb_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_valid     = 1'b0;
    sel_beat      = '0;
    sel_beat.id   = grant_q;
    s_axis_tready = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_valid        = s_axis_tvalid[i];
        sel_beat.data    = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_beat.keep    = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_beat.last    = s_axis_tlast[i];
        sel_beat.user    = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        s_axis_tready[i] = in_ready;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      STATE_IDLE: begin
        if (arb_found) begin
          grant_d = arb_idx;
          state_d = STATE_XFER;
        end
      end
      default: begin
        if (in_fire && sel_beat.last) begin
          last_grant_d = grant_q;
          state_d      = STATE_IDLE;
        end
      end
    endcase
  end

  // The skid slot only fills while the output slot is full and stalled.
  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    load_out     = 1'b0;
    load_skid    = 1'b0;
    move_skid    = 1'b0;
    if (!out_valid_q || m_axis_tready) begin
      if (skid_valid_q) begin
        move_skid    = 1'b1;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        load_out    = 1'b1;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      load_skid    = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= STATE_IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_WIDTH'(S_COUNT - 1);
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // NOTE: payload registers carry no reset; their valid flags above gate every use.
  always_ff @(posedge clk) begin
    if (load_out) begin
      out_beat_q <= sel_beat;
    end else if (move_skid) begin
      out_beat_q <= skid_beat_q;
    end
    if (load_skid) begin
      skid_beat_q <= sel_beat;
    end
  end

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_beat_q.data;
  assign m_axis_tkeep  = out_beat_q.keep;
  assign m_axis_tlast  = out_beat_q.last;
  assign m_axis_tid    = out_beat_q.id;
  assign m_axis_tuser  = out_beat_q.user;
  assign busy          = (state_q == STATE_XFER);
  assign grant_idx     = grant_q;

endmodule

// File: doc/axis_pkt_arbiter.md
AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

Interface
REQ-001 SHALL have parameter S_COUNT, default 4: number of requesting input streams, 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: tdata width per stream in bits, a multiple of 8.
REQ-003 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8: tkeep width per stream.
REQ-004 SHALL have parameter USER_WIDTH, default 1: tuser width per stream.
REQ-005 SHALL derive localparam ID_WIDTH = max(1, clog2(S_COUNT)); it is not overridable.
REQ-006 SHALL have ports, in order:
 clk  in  1  sole clock, all logic on rising edge.
 rst_n  in  1  asynchronous, active-low reset.
 s_axis_tdata  in  S_COUNT*DATA_WIDTH  input data; port i occupies slice i.
 s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  input byte enables.
 s_axis_tvalid  in  S_COUNT  per-port valid.
 s_axis_tready  out  S_COUNT  per-port ready.
 s_axis_tlast  in  S_COUNT  per-port end of packet.
 s_axis_tuser  in  S_COUNT*USER_WIDTH  per-port sideband.
 m_axis_tdata  out  DATA_WIDTH  arbitrated data, feeds the shared width adapter.
 m_axis_tkeep  out  KEEP_WIDTH  arbitrated byte enables.
 m_axis_tvalid  out  1  output valid.
 m_axis_tready  in  1  output ready.
 m_axis_tlast  out  1  end of packet.
 m_axis_tid  out  ID_WIDTH  index of the source port of the current beat.
 m_axis_tuser  out  USER_WIDTH  sideband of the current beat.
 busy  out  1  high while a grant is held (state XFER).
 grant_idx  out  ID_WIDTH  currently/last granted port index.

Function
REQ-007 SHALL implement a two-state FSM: IDLE, XFER.
REQ-008 SHALL, in IDLE with any s_axis_tvalid high, grant the first valid port searching upward from (last_grant+1) mod S_COUNT, then enter XFER on the next edge.
REQ-009 SHALL, in IDLE with no s_axis_tvalid high, remain in IDLE, with all s_axis_tready low.
REQ-010 SHALL, in XFER, drive s_axis_tready[g] high only for the granted port g, and only when the output stage can accept a beat; all other bits low.
REQ-011 SHALL hold the grant for the whole packet regardless of s_axis_tvalid[g] gaps; there is no timeout and no preemption.
REQ-012 SHALL, on an accepted beat of port g with s_axis_tlast[g]=1, set last_grant<=g and return to IDLE; the next arbitration then starts one cycle later (one-cycle bubble between packets).
REQ-013 SHALL register the output through a 2-entry skid buffer: m_axis_tvalid rises exactly 1 cycle after the input handshake; throughput is one beat/cycle with no combinational path from m_axis_tready to s_axis_tready.
REQ-014 SHALL pass tdata, tkeep, tlast and tuser unmodified and set m_axis_tid=g for every beat of the packet.
REQ-015 SHALL keep m_axis_* stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-016 SHALL treat a single-beat packet (tlast on first beat) as a complete grant cycle: IDLE->XFER->IDLE.
REQ-017 SHALL, with requests from all ports continuously present, serve ports in strict rotation 0,1,...,S_COUNT-1,0,...
REQ-018 SHALL ignore s_axis_tvalid changes on non-granted ports during XFER; they are considered only at the next IDLE.
REQ-019 SHALL drive grant_idx = g in XFER and retain the last grant in IDLE; busy = (state==XFER).

Reset
REQ-020 SHALL, on rst_n low, asynchronously force: state IDLE, last_grant=S_COUNT-1, skid buffer empty, m_axis_tvalid=0, s_axis_tready=0, busy=0, grant_idx=0.
REQ-021 SHALL, on reset asserted mid-packet, discard buffered beats and the partial packet; after release, the first grant goes to the lowest valid port.
REQ-022 SHALL resume operation on the first rising edge after rst_n deasserts, and no output handshake SHALL occur while rst_n is low.

Verification
REQ-023 SHALL pass: after reset, ports 0 and 2 each request a 3-beat packet simultaneously -> port 0 packet out (tid=0), one-cycle bubble, then port 2 packet (tid=2), data bit-exact.
REQ-024 SHALL pass: all 4 ports requesting 1-beat packets continuously for 8 packets -> tid sequence 0,1,2,3,0,1,2,3.
REQ-025 SHALL pass: port 1 drops tvalid for 5 cycles mid-packet while port 3 requests -> grant stays 1, port 3 s_axis_tready=0 until port 1's tlast is accepted.
REQ-026 SHALL pass: m_axis_tready held low 10 cycles during a 6-beat packet -> at most 2 beats buffered, output stable while stalled, no beat lost or duplicated.
REQ-027 SHALL pass: rst_n pulsed low during beat 2 of a 4-beat packet -> m_axis_tvalid=0 immediately, busy=0, after release a new port-0 request is granted first.
REQ-028 SHALL pass: random valid/ready toggling on all ports, 10k beats, S_COUNT=3 -> per-port packet order preserved, every output packet contiguous, tid matches source.
